// File: rtl/alto_task_mpc_sequencer.sv
// Next micro-PC formation with per-task saved PCs and Alto-style deferred task switch.
// A TASK request arms a switch that completes on the following microcycle step.
module alto_task_mpc_sequencer #(
   parameter int unsigned TASKS  = 16,
   parameter int unsigned TASK_W = 4,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              step_i,
   input  logic [ADDR_W-1:0] next_i,
   input  logic [ADDR_W-1:0] modifiers_i,
   input  logic              task_switch_i,
   input  logic [TASK_W-1:0] pending_task_i,
   output logic [ADDR_W-1:0] mpc_o,
   output logic [TASK_W-1:0] task_o,
   output logic              switch_armed_o,
   output logic              task_changed_o
);

   logic [ADDR_W-1:0] addr_c;
   logic [ADDR_W-1:0] mpc_q, mpc_d;
   logic [TASK_W-1:0] task_q, task_d;
   logic [TASK_W-1:0] next_task_q, next_task_d;
   logic              armed_q, armed_d;
   logic              changed_q, changed_d;
   logic [ADDR_W-1:0] save_q [TASKS];
   logic [ADDR_W-1:0] save_d [TASKS];

   assign addr_c = next_i | modifiers_i;

   always_comb begin
      mpc_d       = mpc_q;
      task_d      = task_q;
      next_task_d = next_task_q;
      armed_d     = armed_q;
      changed_d   = changed_q;
      save_d      = save_q;
      if (step_i) begin
         // Outgoing (or continuing) task always records the address it computed.
         save_d[task_q] = addr_c;
         if (armed_q && (next_task_q != task_q)) begin
            task_d    = next_task_q;
            mpc_d     = save_q[next_task_q];
            changed_d = 1'b1;
         end else begin
            mpc_d     = addr_c;
            changed_d = 1'b0;
         end
         armed_d = 1'b0;
         if (task_switch_i) begin
            armed_d     = 1'b1;
            next_task_d = pending_task_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mpc_q       <= '0;
         task_q      <= '0;
         next_task_q <= '0;
         armed_q     <= 1'b0;
         changed_q   <= 1'b0;
         for (int unsigned t = 0; t < TASKS; t++) begin
            save_q[t] <= ADDR_W'(t);
         end
      end else begin
         mpc_q       <= mpc_d;
         task_q      <= task_d;
         next_task_q <= next_task_d;
         armed_q     <= armed_d;
         changed_q   <= changed_d;
         save_q      <= save_d;
      end
   end

   assign mpc_o          = mpc_q;
   assign task_o         = task_q;
   assign switch_armed_o = armed_q;
   assign task_changed_o = changed_q;

endmodule

// File: tb/tb_alto_task_mpc_sequencer.sv
// Directed and random checks of the task micro-PC sequencer against a behavioural model.
module tb_alto_task_mpc_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       step_i;
   logic [9:0] next_i;
   logic [9:0] modifiers_i;
   logic       task_switch_i;
   logic [3:0] pending_task_i;
   logic [9:0] mpc_o;
   logic [3:0] task_o;
   logic       switch_armed_o;
   logic       task_changed_o;

   int total = 0;
   int bad   = 0;

   // Behavioural model state
   logic [9:0] save_m [16];
   logic [9:0] mpc_m;
   logic [3:0] task_m;
   logic [3:0] nt_m;
   logic       armed_m;
   logic       chg_m;

   always #5 clk_i = ~clk_i;

   alto_task_mpc_sequencer #(.TASKS(16), .TASK_W(4), .ADDR_W(10)) dut (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .step_i         (step_i),
      .next_i         (next_i),
      .modifiers_i    (modifiers_i),
      .task_switch_i  (task_switch_i),
      .pending_task_i (pending_task_i),
      .mpc_o          (mpc_o),
      .task_o         (task_o),
      .switch_armed_o (switch_armed_o),
      .task_changed_o (task_changed_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int t = 0; t < 16; t++) save_m[t] = 10'(t);
      mpc_m = '0; task_m = '0; nt_m = '0; armed_m = 1'b0; chg_m = 1'b0;
   endtask

   task automatic model_step(input logic [9:0] nx, input logic [9:0] md,
                             input bit ts, input logic [3:0] pt);
      logic [9:0] a;
      logic [3:0] outgoing;
      a = nx | md;
      outgoing = task_m;
      if (armed_m && nt_m != task_m) begin
         mpc_m  = save_m[nt_m];
         task_m = nt_m;
         chg_m  = 1'b1;
      end else begin
         mpc_m = a;
         chg_m = 1'b0;
      end
      save_m[outgoing] = a;
      armed_m = ts;
      if (ts) nt_m = pt;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".mpc"},     32'(mpc_o),          32'(mpc_m));
      chk({tag, ".task"},    32'(task_o),         32'(task_m));
      chk({tag, ".armed"},   32'(switch_armed_o), 32'(armed_m));
      chk({tag, ".changed"}, 32'(task_changed_o), 32'(chg_m));
   endtask

   task automatic cyc(input string tag, input bit st, input logic [9:0] nx,
                      input logic [9:0] md, input bit ts, input logic [3:0] pt);
      step_i = st; next_i = nx; modifiers_i = md;
      task_switch_i = ts; pending_task_i = pt;
      @(posedge clk_i);
      if (st) model_step(nx, md, ts, pt);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst_n_i = 1'b0; step_i = 1'b0; next_i = '0; modifiers_i = '0;
      task_switch_i = 1'b0; pending_task_i = '0;
      model_reset();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      check_all("reset");

      // OR merge and hold
      cyc("or", 1'b1, 10'h120, 10'h001, 1'b0, 4'd0);
      chk("or.const", 32'(mpc_o), 32'h121);
      for (int i = 0; i < 3; i++) begin
         cyc("hold", 1'b0, 10'($urandom), 10'($urandom), 1'($urandom), 4'($urandom));
         chk("hold.const", 32'(mpc_o), 32'h121);
      end

      // Deferred switch 0 -> 5
      cyc("stepA", 1'b1, 10'h040, 10'h000, 1'b1, 4'd5);
      chk("stepA.mpc", 32'(mpc_o), 32'h040);
      chk("stepA.armed", 32'(switch_armed_o), 32'd1);
      cyc("stepB", 1'b1, 10'h041, 10'h000, 1'b0, 4'd0);
      chk("stepB.task", 32'(task_o), 32'd5);
      chk("stepB.mpc", 32'(mpc_o), 32'h005);
      chk("stepB.changed", 32'(task_changed_o), 32'd1);

      // Return 5 -> 0, resumes at saved 0x041
      cyc("retA", 1'b1, 10'h000, 10'h000, 1'b1, 4'd0);
      cyc("retB", 1'b1, 10'h010, 10'h000, 1'b0, 4'd0);
      chk("ret.task", 32'(task_o), 32'd0);
      chk("ret.mpc", 32'(mpc_o), 32'h041);

      // Self switch
      cyc("selfA", 1'b1, 10'h000, 10'h000, 1'b1, 4'd0);
      cyc("selfB", 1'b1, 10'h200, 10'h003, 1'b0, 4'd0);
      chk("self.mpc", 32'(mpc_o), 32'h203);
      chk("self.changed", 32'(task_changed_o), 32'd0);
      chk("self.armed", 32'(switch_armed_o), 32'd0);

      // Back-to-back TASK
      cyc("b2bA", 1'b1, 10'h000, 10'h000, 1'b1, 4'd7);
      cyc("b2bB", 1'b1, 10'h001, 10'h000, 1'b1, 4'd2);
      chk("b2bB.task", 32'(task_o), 32'd7);
      chk("b2bB.armed", 32'(switch_armed_o), 32'd1);
      cyc("b2bC", 1'b1, 10'h002, 10'h000, 1'b0, 4'd0);
      chk("b2bC.task", 32'(task_o), 32'd2);
      chk("b2bC.mpc", 32'(mpc_o), 32'h002);

      // Asynchronous reset mid-cycle with an armed switch
      cyc("arm", 1'b1, 10'h055, 10'h000, 1'b1, 4'd9);
      step_i = 1'b0;
      #2;
      rst_n_i = 1'b0;
      model_reset();
      #1;
      chk("arst.mpc", 32'(mpc_o), 32'd0);
      chk("arst.task", 32'(task_o), 32'd0);
      chk("arst.armed", 32'(switch_armed_o), 32'd0);
      chk("arst.changed", 32'(task_changed_o), 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      cyc("rs5A", 1'b1, 10'h100, 10'h000, 1'b1, 4'd5);
      cyc("rs5B", 1'b1, 10'h101, 10'h000, 1'b0, 4'd0);
      chk("rs5.task", 32'(task_o), 32'd5);
      chk("rs5.mpc", 32'(mpc_o), 32'h005);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc("rnd", ($urandom_range(3) != 0), 10'($urandom), 10'($urandom) & 10'h00f,
             ($urandom_range(3) == 0), 4'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
